// File: rtl/mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_pkg : shared constants and FSM encoding for the memory initiator  |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package mem_pkg;

  localparam int MEM_WORDS  = 64;
  localparam int WORD_BYTES = 4;
  localparam int MEM_BYTES  = MEM_WORDS * WORD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_STORE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_addr_check : word-alignment and range check of a byte address     |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LIMIT_BYTES = MEM_BYTES
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              misaligned_o,
  output logic              out_of_range_o,
  output logic              err_o
);

  // Full-width unsigned compare so high addresses never wrap into range.
  localparam logic [ADDR_W-1:0] c_limit = ADDR_W'(LIMIT_BYTES);

  assign misaligned_o   = |addr_i[1:0];
  assign out_of_range_o = (addr_i >= c_limit);
  assign err_o          = misaligned_o | out_of_range_o;

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_ctrl : arbitrates core fetch and load/store onto memory    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = mem_pkg::MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_pc,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_inst,
  input  logic [DATA_W-1:0] mem_data_out
);

  import mem_pkg::*;

  state_e              state_q, state_d;
  logic                accept_ls, accept_fetch;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_misaligned, w_out_of_range, w_chk_err, w_sel_err;

  logic                fetch_valid_q, fetch_err_q, ls_done_q, ls_err_q, busy_q;
  logic [DATA_W-1:0]   fetch_inst_q, ls_rdata_q, mem_write_data_q;
  logic [ADDR_W-1:0]   mem_pc_q, mem_read_addr_q, mem_write_addr_q;
  logic                mem_we_q;

  // Load/store wins arbitration, so its address is the one checked when both request.
  assign w_sel_addr = ls_req ? ls_addr : fetch_addr;

  mem_addr_check #(
    .ADDR_W      (ADDR_W),
    .LIMIT_BYTES (MEM_WORDS * WORD_BYTES)
  ) u_addr_check (
    .addr_i         (w_sel_addr),
    .misaligned_o   (w_misaligned),
    .out_of_range_o (w_out_of_range),
    .err_o          (w_chk_err)
  );

  assign w_sel_err = w_chk_err | w_misaligned | w_out_of_range;

  always_comb begin
    state_d      = state_q;
    accept_ls    = 1'b0;
    accept_fetch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ls_req) begin
          accept_ls = 1'b1;
          if (w_sel_err)  state_d = ST_RESP;
          else if (ls_we) state_d = ST_STORE;
          else            state_d = ST_LOAD;
        end else if (fetch_req) begin
          accept_fetch = 1'b1;
          state_d      = w_sel_err ? ST_RESP : ST_FETCH;
        end
      end
      ST_FETCH, ST_LOAD, ST_STORE: state_d = ST_RESP;
      ST_RESP:                     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      fetch_valid_q    <= 1'b0;
      fetch_err_q      <= 1'b0;
      fetch_inst_q     <= '0;
      ls_done_q        <= 1'b0;
      ls_err_q         <= 1'b0;
      ls_rdata_q       <= '0;
      mem_pc_q         <= '0;
      mem_read_addr_q  <= '0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      mem_we_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != ST_IDLE);
      fetch_valid_q <= 1'b0;
      ls_done_q     <= 1'b0;
      mem_we_q      <= 1'b0;

      if (accept_ls) begin
        if (w_sel_err) begin
          ls_done_q  <= 1'b1;
          ls_err_q   <= 1'b1;
          ls_rdata_q <= '0;
        end else if (ls_we) begin
          mem_write_addr_q <= ls_addr;
          mem_write_data_q <= ls_wdata;
          mem_we_q         <= 1'b1;
        end else begin
          mem_read_addr_q <= ls_addr;
        end
      end

      if (accept_fetch) begin
        if (w_sel_err) begin
          fetch_valid_q <= 1'b1;
          fetch_err_q   <= 1'b1;
          fetch_inst_q  <= '0;
        end else begin
          mem_pc_q <= fetch_addr;
        end
      end

      case (state_q)
        ST_FETCH: begin
          fetch_inst_q  <= mem_inst;
          fetch_valid_q <= 1'b1;
          fetch_err_q   <= 1'b0;
        end
        ST_LOAD: begin
          ls_rdata_q <= mem_data_out;
          ls_done_q  <= 1'b1;
          ls_err_q   <= 1'b0;
        end
        ST_STORE: begin
          ls_rdata_q <= '0;
          ls_done_q  <= 1'b1;
          ls_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign fetch_valid    = fetch_valid_q;
  assign fetch_inst     = fetch_inst_q;
  assign fetch_err      = fetch_err_q;
  assign ls_done        = ls_done_q;
  assign ls_rdata       = ls_rdata_q;
  assign ls_err         = ls_err_q;
  assign busy           = busy_q;
  assign mem_pc         = mem_pc_q;
  assign mem_read_addr  = mem_read_addr_q;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;

  // Reset arriving during STORE must suppress the write at that same edge.
  assign mem_write_enable = mem_we_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_access_ctrl : scoreboard bench with a 64-word memory model     |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid, fetch_err;
  logic [31:0] fetch_inst;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done, ls_err;
  logic [31:0] ls_rdata;
  logic        busy;
  logic [31:0] mem_pc, mem_read_addr, mem_write_addr, mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_inst, mem_data_out;

  logic [31:0] mem [64];
  int          we_cnt = 0;
  logic [31:0] last_we_addr = '0;

  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_valid      (fetch_valid),
    .fetch_inst       (fetch_inst),
    .fetch_err        (fetch_err),
    .ls_req           (ls_req),
    .ls_we            (ls_we),
    .ls_addr          (ls_addr),
    .ls_wdata         (ls_wdata),
    .ls_done          (ls_done),
    .ls_rdata         (ls_rdata),
    .ls_err           (ls_err),
    .busy             (busy),
    .mem_pc           (mem_pc),
    .mem_read_addr    (mem_read_addr),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_inst         (mem_inst),
    .mem_data_out     (mem_data_out)
  );

  assign mem_inst     = mem[mem_pc[7:2]];
  assign mem_data_out = mem[mem_read_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_write_addr[7:2]] <= mem_write_data;
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_write_addr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (fetch_valid || ls_done) begin
      if (fetch_valid && ls_done)
        check("both_pulses", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, ls_done}, {31'd0, ~ls_done});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind_is_ls", {31'd0, ls_done}, {31'd0, e.is_ls});
        if (ls_done) begin
          check("ls_rdata", ls_rdata, e.data);
          check("ls_err", {31'd0, ls_err}, {31'd0, e.err});
        end else begin
          check("fetch_inst", fetch_inst, e.data);
          check("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic access(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_err);
    exp_t e;
    int   lat;
    bit   seen;
    e.is_ls = is_ls; e.data = exp_d; e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr;
    end
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (is_ls ? ls_done : fetch_valid) seen = 1'b1;
    end
    ls_req    = 1'b0;
    fetch_req = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) check("latency", lat, exp_err ? 32'd1 : 32'd2);
  endtask

  initial begin
    int snap;
    int gap;
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[2] = 32'h0A0B0C0D;
    mem[8] = 32'h5555_5555;

    repeat (3) @(negedge clk);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_ls_done", {31'd0, ls_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    check("rst_mem_write_addr", mem_write_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain fetch of word 2
    access(1'b0, 1'b0, 32'h08, 32'h0, 32'h0A0B0C0D, 1'b0);

    // Store then load back
    snap = we_cnt;
    access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
    check("store_we_pulses", we_cnt - snap, 32'd1);
    check("store_we_addr", last_we_addr, 32'h40);
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);

    // Simultaneous requests: load wins, fetch follows three cycles later
    begin
      exp_t e1, e2;
      e1.is_ls = 1'b1; e1.data = 32'h1000_0004; e1.err = 1'b0;
      e2.is_ls = 1'b0; e2.data = 32'h1000_0003; e2.err = 1'b0;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
      fetch_req = 1'b1; fetch_addr = 32'h0C;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (ls_done) seen = 1'b1;
      end
      ls_req = 1'b0;
      check("arb_ls_done_seen", {31'd0, seen}, 32'd1);
      gap  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        gap++;
        if (fetch_valid) seen = 1'b1;
      end
      fetch_req = 1'b0;
      check("arb_fetch_seen", {31'd0, seen}, 32'd1);
      check("arb_fetch_gap", gap, 32'd3);
    end

    // Error cases: no memory access, one-cycle latency, data zero
    snap = we_cnt;
    access(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
    access(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1);
    access(1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    check("err_no_we", we_cnt - snap, 32'd0);

    // Last valid word
    snap = we_cnt;
    access(1'b1, 1'b1, 32'hFC, 32'h12345678, 32'h0, 1'b0);
    check("last_we_pulses", we_cnt - snap, 32'd1);
    access(1'b1, 1'b0, 32'hFC, 32'h0, 32'h12345678, 1'b0);

    // Reset during STORE aborts the write and the response
    snap = we_cnt;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check("abort_in_store_we", {31'd0, mem_write_enable}, 32'd1);
    rst = 1'b1;
    ls_req = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ls_done", {31'd0, ls_done}, 32'd0);
    check("abort_mem_write_addr", mem_write_addr, 32'd0);
    check("abort_mem_write_data", mem_write_data, 32'd0);
    check("abort_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_write", mem[8], 32'h5555_5555);
    check("abort_we_pulses", we_cnt - snap, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
